// File: rtl/log_lane_mover.sv
// River log position generator: once per frame sweeps every lane, stepping its logs at a per-lane rate.
// Optional LOG_LANE_MOVER_SPEEDUP_EN enables the speed_up input that raises speed_level.

module log_lane_mover_lane #(
    parameter int LANE          = 0,
    parameter int LOGS_PER_LANE = 4,
    parameter int SCREEN_W      = 640,
    parameter int LOG_SPACING   = 160,
    parameter int LANE_STAGGER  = 48,
    parameter int BASE_PERIOD   = 2,
    parameter int LVL_W         = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               proc_i,
    input  logic [LVL_W-1:0]                   speed_level_i,
    output logic [LOGS_PER_LANE-1:0][10:0]     x_o,
    output logic                               step_o
);
    localparam int CNT_W     = $clog2(BASE_PERIOD + LANE + 1);
    localparam bit DIR_RIGHT = (LANE % 2) == 0;

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [LOGS_PER_LANE-1:0][10:0]   x_q, x_d;
    logic                             step_q, step_d;
    int                               period;

    always_comb begin
        period = BASE_PERIOD + LANE - int'(speed_level_i);
        if (period < 1) period = 1;
        cnt_d  = cnt_q;
        x_d    = x_q;
        step_d = 1'b0;
        if (proc_i) begin
            // >= keeps a lane moving when speed_level shrinks the period below the count
            if (int'(cnt_q) >= period - 1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                for (int j = 0; j < LOGS_PER_LANE; j++) begin
                    if (DIR_RIGHT)
                        x_d[j] = (x_q[j] == 11'(SCREEN_W - 1)) ? 11'd0 : x_q[j] + 11'd1;
                    else
                        x_d[j] = (x_q[j] == 11'd0) ? 11'(SCREEN_W - 1) : x_q[j] - 11'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
            for (int j = 0; j < LOGS_PER_LANE; j++)
                x_q[j] <= 11'((j * LOG_SPACING + LANE * LANE_STAGGER) % SCREEN_W);
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            x_q    <= x_d;
        end
    end

    assign x_o    = x_q;
    assign step_o = step_q;
endmodule

module log_lane_mover #(
    parameter int NUM_LANES     = 5,
    parameter int LOGS_PER_LANE = 4,
    parameter int SCREEN_W      = 640,
    parameter int LOG_SPACING   = 160,
    parameter int LANE_STAGGER  = 48,
    parameter int LANE0_Y       = 80,
    parameter int LANE_PITCH    = 16,
    parameter int BASE_PERIOD   = 2,
    localparam int NUM_LOGS     = NUM_LANES * LOGS_PER_LANE
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 startOfFrame,
    input  logic                 pause,
    input  logic                 speed_up,
    output logic [10:0]          ObjectStartX [NUM_LOGS-1:0],
    output logic [10:0]          ObjectStartY [NUM_LOGS-1:0],
    output logic [NUM_LANES-1:0] lane_step,
    output logic [NUM_LANES-1:0] lane_dir,
    output logic                 busy,
    output logic                 update_done
);
    localparam int LVL_MAX = BASE_PERIOD + NUM_LANES - 2;
    localparam int LVL_W   = (LVL_MAX > 0) ? $clog2(LVL_MAX + 1) : 1;
    localparam int IDX_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                                         state_q;
    logic [IDX_W-1:0]                               lane_idx_q;
    logic                                           done_q;
    logic [LVL_W-1:0]                               speed_lvl;
    logic [NUM_LANES-1:0][LOGS_PER_LANE-1:0][10:0]  lane_x;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            lane_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (startOfFrame && !pause) begin
                    state_q    <= UPDATE;
                    lane_idx_q <= '0;
                end
                UPDATE: if (lane_idx_q == IDX_W'(NUM_LANES - 1)) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    lane_idx_q <= lane_idx_q + IDX_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LOG_LANE_MOVER_SPEEDUP_EN
    always_ff @(posedge CLK) begin
        if (!RESETn)
            speed_lvl <= '0;
        else if (speed_up && speed_lvl < LVL_W'(LVL_MAX))
            speed_lvl <= speed_lvl + LVL_W'(1);
    end
`else
    logic unused_speed_up;
    assign unused_speed_up = speed_up;
    assign speed_lvl       = '0;
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        log_lane_mover_lane #(
            .LANE(l), .LOGS_PER_LANE(LOGS_PER_LANE), .SCREEN_W(SCREEN_W),
            .LOG_SPACING(LOG_SPACING), .LANE_STAGGER(LANE_STAGGER),
            .BASE_PERIOD(BASE_PERIOD), .LVL_W(LVL_W)
        ) u_lane (
            .clk_i         (CLK),
            .rst_n_i       (RESETn),
            .proc_i        (state_q == UPDATE && lane_idx_q == IDX_W'(l)),
            .speed_level_i (speed_lvl),
            .x_o           (lane_x[l]),
            .step_o        (lane_step[l])
        );
        assign lane_dir[l] = ((l % 2) == 0);
        for (genvar j = 0; j < LOGS_PER_LANE; j++) begin : g_log
            assign ObjectStartX[l*LOGS_PER_LANE+j] = lane_x[l][j];
            assign ObjectStartY[l*LOGS_PER_LANE+j] = 11'(LANE0_Y + l * LANE_PITCH);
        end
    end

    assign busy        = (state_q == UPDATE);
    assign update_done = done_q;
endmodule

// File: tb/tb_log_lane_mover.sv
// Randomized scoreboard bench for log_lane_mover: a frame-level model predicts each sweep, a monitor checks it.
module tb_log_lane_mover;
    localparam int NL = 5, LPL = 4, NLOG = NL * LPL, SW = 640;
    typedef logic [NLOG-1:0][10:0] xvec_t;

    logic CLK = 1'b0;
    logic RESETn, startOfFrame, pause, speed_up;
    logic [10:0] ObjectStartX [NLOG-1:0];
    logic [10:0] ObjectStartY [NLOG-1:0];
    logic [NL-1:0] lane_step, lane_dir;
    logic busy, update_done;

    log_lane_mover dut (
        .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame), .pause(pause),
        .speed_up(speed_up), .ObjectStartX(ObjectStartX), .ObjectStartY(ObjectStartY),
        .lane_step(lane_step), .lane_dir(lane_dir), .busy(busy), .update_done(update_done)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    xvec_t         qx[$];
    logic [NL-1:0] qm[$];

    // reference model: frames since last step per lane, plain modular positions
    int mx[NLOG];
    int mframes[NL];
    int mlvl;
    int busy_left;

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) begin
            mframes[l] = 0;
            for (int j = 0; j < LPL; j++) mx[l*LPL+j] = (j * 160 + l * 48) % SW;
        end
        mlvl = 0;
        busy_left = 0;
    endfunction

    function automatic void model_sweep();
        logic [NL-1:0] mask;
        xvec_t v;
        int p;
        mask = '0;
        for (int l = 0; l < NL; l++) begin
            p = 2 + l - mlvl;
            if (p < 1) p = 1;
            mframes[l]++;
            if (mframes[l] >= p) begin
                mframes[l] = 0;
                mask[l] = 1'b1;
                for (int j = 0; j < LPL; j++)
                    mx[l*LPL+j] = (l % 2 == 0) ? (mx[l*LPL+j] + 1) % SW : (mx[l*LPL+j] + SW - 1) % SW;
            end
        end
        for (int i = 0; i < NLOG; i++) v[i] = 11'(mx[i]);
        qx.push_back(v);
        qm.push_back(mask);
    endfunction

    function automatic xvec_t dut_x();
        xvec_t v;
        for (int i = 0; i < NLOG; i++) v[i] = ObjectStartX[i];
        return v;
    endfunction

    function automatic xvec_t model_x();
        xvec_t v;
        for (int i = 0; i < NLOG; i++) v[i] = 11'(mx[i]);
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit sof, input bit pau, input bit su);
        @(negedge CLK);
        startOfFrame = sof;
        pause        = pau;
        speed_up     = su && (busy_left == 0);
        if (busy_left > 0) begin
            busy_left--;
        end else begin
`ifdef LOG_LANE_MOVER_SPEEDUP_EN
            if (su && mlvl < 5) mlvl++;
`endif
            if (sof && !pau) begin
                model_sweep();
                busy_left = NL;
            end
        end
    endtask

    task automatic check_static(input string tag);
        logic [255:0] ey, ay;
        ey = '0; ay = '0;
        for (int i = 0; i < NLOG; i++) begin
            ey[i*11 +: 11] = 11'(80 + (i / LPL) * 16);
            ay[i*11 +: 11] = ObjectStartY[i];
        end
        check({tag, "_y"}, ay, ey);
        check({tag, "_dir"}, 256'(lane_dir), 256'(5'b10101));
    endtask

    // monitor: follows each sweep edge by edge against the queued expectation
    int k = -1;
    always begin
        logic [NL-1:0] e;
        @(posedge CLK);
        #1;
        if (!RESETn) begin
            qx.delete();
            qm.delete();
            k = -1;
        end else if (k < 0) begin
            if (busy) begin
                n_tests++;
                if (qx.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_sweep: busy=1 with no sweep expected");
                end else k = 0;
            end else begin
                check("idle_quiet", 256'({lane_step, update_done}), 256'(0));
            end
        end else begin
            k++;
            e = '0;
            e[k-1] = qm[0][k-1];
            check("lane_step", 256'(lane_step), 256'(e));
            check("busy_flag", 256'(busy), 256'(k < NL));
            check("update_done", 256'(update_done), 256'(k == NL));
            if (k == NL) begin
                check("sweep_x", 256'(dut_x()), 256'(qx[0]));
                void'(qx.pop_front());
                void'(qm.pop_front());
                k = -1;
            end
        end
    end

    task automatic drain();
        int guard;
        repeat (NL + 2) cycle(0, 0, 0);
        guard = 0;
        while (qx.size() != 0 && guard < 20) begin
            cycle(0, 0, 0);
            guard++;
        end
        n_tests++;
        if (qx.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d sweeps still pending", qx.size());
        end
    endtask

    initial begin
        RESETn = 1'b0; startOfFrame = 1'b0; pause = 1'b0; speed_up = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        check("reset_x", 256'(dut_x()), 256'(model_x()));
        check("reset_x4", 256'(ObjectStartX[4]), 256'(48));
        check("reset_busy", 256'(busy), 256'(0));
        check_static("reset");

        for (int c = 0; c < 6000; c++)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 150) == 0);
        drain();
        check("random_x", 256'(dut_x()), 256'(model_x()));

        for (int n = 0; n < 10; n++) begin
            cycle(1, 1, 0);
            cycle(0, 1, 0);
        end
        drain();
        check("pause_hold", 256'(dut_x()), 256'(model_x()));

        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        @(negedge CLK);
        RESETn = 1'b0;
        startOfFrame = 1'b0;
        model_reset();
        @(negedge CLK);
        RESETn = 1'b1;
        check("midreset_x", 256'(dut_x()), 256'(model_x()));
        check("midreset_busy", 256'({busy, update_done, lane_step}), 256'(0));

        for (int n = 0; n < 4; n++) begin
            cycle(1, 0, 0);
            repeat (NL + 1) cycle(0, 0, 0);
        end
        drain();
        check("post_reset_x", 256'(dut_x()), 256'(model_x()));
        check_static("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
